pipe_stage_reg: RTL

- Generic, parametrised inter-stage pipeline register (ID/EX, EX/MEM, ...). Successor to the fixed-field ID/EX latch.
- Carries an opaque payload of PAYLOAD_W bits with a valid bit.
- Obeys the global stall vector at a configurable stage index.
- Handles branch flush, including a programmable number of squash slots for flushes that arrive while the upstream stage is stalled.

---
 rtl/pipe_stage_reg_if.sv | 23 ++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream payload channel of a pipeline stage register
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 128
);
  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall, flush and squash slots
// Optional performance counters are enabled with macro PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W  = 128,
  parameter int                   STALL_W    = 6,
  parameter int                   STAGE      = 2,
  parameter int                   KILL_SLOTS = 1,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE  = {PAYLOAD_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  pipe_stage_reg_if.slave    bus,
  output logic               kill_pending
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_squashed
`endif
);

  localparam logic [3:0] KILL_INIT = 4'(KILL_SLOTS);

  logic                 up;
  logic                 dn;
  logic                 unused_stall;
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic [3:0]           kill_cnt_q, kill_cnt_d;

  assign up           = stall[STAGE];
  assign dn           = stall[STAGE+1];
  assign unused_stall = ^stall;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    kill_cnt_d = kill_cnt_q;
    if (flush_i) begin
      // A flush while upstream is stalled must also squash the stalled instruction(s) yet to arrive.
      valid_d    = 1'b0;
      data_d     = NOP_VALUE;
      kill_cnt_d = up ? KILL_INIT : 4'd0;
    end else if (up) begin
      if (!dn) begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
      end
    end else if (kill_cnt_q != 4'd0) begin
      valid_d    = 1'b0;
      data_d     = NOP_VALUE;
      kill_cnt_d = kill_cnt_q - 4'd1;
    end else begin
      valid_d = bus.in_valid;
      data_d  = bus.in_valid ? bus.in_data : NOP_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      data_q     <= NOP_VALUE;
      kill_cnt_q <= 4'd0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign kill_pending  = (kill_cnt_q != 4'd0);

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;
  logic        retire_ev;
  logic        squash_ev;

  assign retire_ev = !flush_i && !up && (kill_cnt_q == 4'd0) && bus.in_valid;
  assign squash_ev = (flush_i && valid_q) ||
                     (!flush_i && !up && (kill_cnt_q != 4'd0) && bus.in_valid);

  always_comb begin
    perf_retired_d  = perf_retired_q;
    perf_squashed_d = perf_squashed_q;
    if (retire_ev && (perf_retired_q != 32'hFFFF_FFFF)) begin
      perf_retired_d = perf_retired_q + 32'd1;
    end
    if (squash_ev && (perf_squashed_q != 32'hFFFF_FFFF)) begin
      perf_squashed_d = perf_squashed_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired_q  <= 32'd0;
      perf_squashed_q <= 32'd0;
    end else begin
      perf_retired_q  <= perf_retired_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_retired  = perf_retired_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule
